// File: rtl/frame12_pkg.sv
// Shared types for the 12-bit frame link: the packed frame shape, its width and the receiver states.
package frame12_pkg;

   typedef logic [0:0][2:4][0:1][3:4] frame_t;

   localparam int FRAME_W = $bits(frame_t);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY,
      HOLD
   } state_t;

endpackage

// File: rtl/frame12_unpack.sv
// Purely combinational mapping from the packed frame_t to its unpacked [3:4][3:2][2:4] twin.
// The n-th unpacked element (rightmost index fastest) carries flat bit FRAME_W-1-n.
module frame12_unpack
   import frame12_pkg::*;
(
   input  frame_t i_frame,
   output logic   o_frame_up [3:4][3:2][2:4]
);

   logic [FRAME_W-1:0] w_flat;

   assign w_flat = i_frame;

   for (genvar gi = 0; gi < 2; gi++) begin : g_i
      for (genvar gj = 0; gj < 2; gj++) begin : g_j
         for (genvar gk = 0; gk < 3; gk++) begin : g_k
            assign o_frame_up[3+gi][3-gj][2+gk] = w_flat[FRAME_W-1-(gi*6 + gj*3 + gk)];
         end
      end
   end

endmodule

// File: rtl/frame12_deser.sv
// Receive end of the serial frame12 link: collects 12 framed bits and holds them as packed and unpacked views.
// Define FRAME12_DESER_PARITY_CHECK_EN to require a trailing even-parity bit and expose parity_err.
module frame12_deser
   import frame12_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin_valid,
   output logic             sin_ready,
   input  logic             sin_sof,
   input  logic             sin_data,
   output logic             frame_valid,
   input  logic             frame_ready,
   output frame_t           frame_pk,
   output logic             frame_up [3:4][3:2][2:4],
   output logic [CNT_W-1:0] frame_cnt,
   output logic             err_resync
`ifdef FRAME12_DESER_PARITY_CHECK_EN
   ,
   output logic             parity_err
`endif
);

   // Without parity the 12th bit goes straight to the output register, so only 11 bits need staging.
`ifdef FRAME12_DESER_PARITY_CHECK_EN
   localparam int SHIFT_W = FRAME_W;
`else
   localparam int SHIFT_W = FRAME_W - 1;
`endif

   state_t             r_state;
   logic [SHIFT_W-1:0] r_shift;
   logic [3:0]         r_bit_cnt;
   logic               r_sin_ready;
   logic               r_frame_valid;
   logic               r_err_resync;
   frame_t             r_frame_pk;
   logic [CNT_W-1:0]   r_frame_cnt;
`ifdef FRAME12_DESER_PARITY_CHECK_EN
   logic               r_parity_err;
`endif

   logic               w_bit_xfer;
   logic               w_frame_xfer;
   logic               w_last_data_bit;
   logic [FRAME_W-1:0] w_shift_next;

   assign w_bit_xfer      = sin_valid && r_sin_ready;
   assign w_frame_xfer    = r_frame_valid && frame_ready;
   assign w_shift_next    = {r_shift[FRAME_W-2:0], sin_data};
   assign w_last_data_bit = (r_bit_cnt == 4'(FRAME_W - 1));

   // NOTE: every state register below uses non-blocking assignments and the asynchronous reset,
   // so all outputs drop to zero the moment rst rises, even mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_sin_ready   <= 1'b0;
         r_frame_valid <= 1'b0;
         r_err_resync  <= 1'b0;
         r_frame_pk    <= '0;
         r_frame_cnt   <= '0;
`ifdef FRAME12_DESER_PARITY_CHECK_EN
         r_parity_err  <= 1'b0;
`endif
      end else begin
         r_err_resync <= 1'b0;
`ifdef FRAME12_DESER_PARITY_CHECK_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               r_sin_ready <= 1'b1;
               if (w_bit_xfer && sin_sof) begin
                  r_shift   <= SHIFT_W'(sin_data);
                  r_bit_cnt <= 4'd1;
                  r_state   <= SHIFT;
               end
            end

            SHIFT: begin
               if (w_bit_xfer) begin
                  if (sin_sof) begin
                     r_shift      <= SHIFT_W'(sin_data);
                     r_bit_cnt    <= 4'd1;
                     r_err_resync <= 1'b1;
                  end else begin
                     r_shift   <= w_shift_next[SHIFT_W-1:0];
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if (w_last_data_bit) begin
`ifdef FRAME12_DESER_PARITY_CHECK_EN
                        r_state <= PARITY;
`else
                        r_frame_pk    <= w_shift_next;
                        r_frame_valid <= 1'b1;
                        r_sin_ready   <= 1'b0;
                        r_state       <= HOLD;
`endif
                     end
                  end
               end
            end

`ifdef FRAME12_DESER_PARITY_CHECK_EN
            PARITY: begin
               if (w_bit_xfer) begin
                  if (sin_sof) begin
                     r_shift      <= SHIFT_W'(sin_data);
                     r_bit_cnt    <= 4'd1;
                     r_err_resync <= 1'b1;
                     r_state      <= SHIFT;
                  end else if (sin_data == ^r_shift) begin
                     r_frame_pk    <= r_shift;
                     r_frame_valid <= 1'b1;
                     r_sin_ready   <= 1'b0;
                     r_bit_cnt     <= '0;
                     r_state       <= HOLD;
                  end else begin
                     r_parity_err <= 1'b1;
                     r_bit_cnt    <= '0;
                     r_state      <= IDLE;
                  end
               end
            end
`endif

            HOLD: begin
               if (w_frame_xfer) begin
                  r_frame_valid <= 1'b0;
                  r_sin_ready   <= 1'b1;
                  r_frame_cnt   <= r_frame_cnt + 1'b1;
                  r_bit_cnt     <= '0;
                  r_state       <= IDLE;
               end
            end

            default: begin
               r_sin_ready <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   frame12_unpack u_unpack (
      .i_frame    (r_frame_pk),
      .o_frame_up (frame_up)
   );

   assign sin_ready   = r_sin_ready;
   assign frame_valid = r_frame_valid;
   assign frame_pk    = r_frame_pk;
   assign frame_cnt   = r_frame_cnt;
   assign err_resync  = r_err_resync;
`ifdef FRAME12_DESER_PARITY_CHECK_EN
   assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_frame12_deser.sv
// Directed bench for frame12_deser: stimulus pushes hand-computed frames into a scoreboard queue,
// a negedge monitor pops and compares on every frame transfer. Honours FRAME12_DESER_PARITY_CHECK_EN.
module tb_frame12_deser;

   logic        clk;
   logic        rst;
   logic        sin_valid;
   logic        sin_ready;
   logic        sin_sof;
   logic        sin_data;
   logic        frame_valid;
   logic        frame_ready;
   logic [11:0] frame_pk;
   logic        frame_up [3:4][3:2][2:4];
   logic [7:0]  frame_cnt;
   logic        err_resync;
`ifdef FRAME12_DESER_PARITY_CHECK_EN
   logic        parity_err;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [11:0] sb_q[$];
   logic [7:0]  exp_cnt;

   frame12_deser #(.CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .sin_valid   (sin_valid),
      .sin_ready   (sin_ready),
      .sin_sof     (sin_sof),
      .sin_data    (sin_data),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_pk    (frame_pk),
      .frame_up    (frame_up),
      .frame_cnt   (frame_cnt),
      .err_resync  (err_resync)
`ifdef FRAME12_DESER_PARITY_CHECK_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reassemble the unpacked view in declared order: element n must equal flat bit 11-n.
   function automatic logic [11:0] up_as_flat();
      logic [11:0] v;
      int n;
      v = '0;
      n = 0;
      for (int i = 3; i <= 4; i++)
         for (int j = 3; j >= 2; j--)
            for (int k = 2; k <= 4; k++) begin
               v[11-n] = frame_up[i][j][k];
               n++;
            end
      return v;
   endfunction

   // Presents one bit and returns #1 after the edge on which it transferred.
   task automatic send_bit(input logic sof, input logic d);
      bit done;
      done      = 1'b0;
      sin_valid = 1'b1;
      sin_sof   = sof;
      sin_data  = d;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (sin_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) check("send_ready_timeout", 32'(sin_ready), 32'd1);
      sin_valid = 1'b0;
      sin_sof   = 1'b0;
   endtask

   task automatic send_word(input logic [11:0] w);
      for (int b = 11; b >= 0; b--) send_bit(b == 11, w[b]);
`ifdef FRAME12_DESER_PARITY_CHECK_EN
      send_bit(1'b0, ^w);
`endif
   endtask

   task automatic expect_frame(input logic [11:0] w);
      sb_q.push_back(w);
      exp_cnt = exp_cnt + 8'd1;
   endtask

   // Scoreboard monitor: one pop per frame transfer, also tracks the accepted-frame count.
   initial begin
      logic [11:0] exp_w;
      logic [7:0]  m_acc;
      m_acc = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_acc = '0;
         end else if (frame_valid && frame_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_frame", 32'(sb_q.size()), 32'd1);
            end else begin
               exp_w = sb_q.pop_front();
               check("sb_frame_pk", 32'(frame_pk), 32'(exp_w));
               check("sb_frame_up", 32'(up_as_flat()), 32'(exp_w));
               check("sb_frame_cnt", 32'(frame_cnt), 32'(m_acc));
            end
            m_acc = m_acc + 8'd1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_wrap;
      rst         = 1'b1;
      sin_valid   = 1'b0;
      sin_sof     = 1'b0;
      sin_data    = 1'b0;
      frame_ready = 1'b1;
      exp_cnt     = '0;
      #3;
      check("rst_sin_ready", 32'(sin_ready), 32'd0);
      check("rst_frame_valid", 32'(frame_valid), 32'd0);
      check("rst_frame_pk", 32'(frame_pk), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_err_resync", 32'(err_resync), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1,0,1,1,0,0,1,0,1,0,0,1 -> 12'hB29, valid one cycle after the last bit.
      expect_frame(12'hB29);
      send_word(12'hB29);
      check("t1_valid_latency", 32'(frame_valid), 32'd1);
      check("t1_up_332", 32'(frame_up[3][3][2]), 32'd1);
      check("t1_up_424", 32'(frame_up[4][2][4]), 32'd1);
      check("t1_up_333", 32'(frame_up[3][3][3]), 32'd0);
      @(posedge clk);
      #1;
      check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

      // Backpressure: outputs stable and input closed while frame_ready is low.
      frame_ready = 1'b0;
      expect_frame(12'h5C3);
      send_word(12'h5C3);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t2_hold_valid", 32'(frame_valid), 32'd1);
         check("t2_hold_pk", 32'(frame_pk), 32'h5C3);
         check("t2_hold_sin_ready", 32'(sin_ready), 32'd0);
      end
      @(posedge clk);
      #1 frame_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t2_release_valid", 32'(frame_valid), 32'd0);
      check("t2_release_sin_ready", 32'(sin_ready), 32'd1);

      // Early SOF after 5 bits aborts the partial frame, then 12'hFFF completes.
      expect_frame(12'hFFF);
      send_bit(1'b1, 1'b0);
      for (int b = 0; b < 5; b++) send_bit(1'b0, 1'b0);
      check("t3_no_resync_yet", 32'(err_resync), 32'd0);
      send_bit(1'b1, 1'b1);
      check("t3_resync_pulse", 32'(err_resync), 32'd1);
      send_bit(1'b0, 1'b1);
      check("t3_resync_one_cycle", 32'(err_resync), 32'd0);
      for (int b = 0; b < 10; b++) send_bit(1'b0, 1'b1);
`ifdef FRAME12_DESER_PARITY_CHECK_EN
      send_bit(1'b0, 1'b0);
`endif
      check("t3_valid", 32'(frame_valid), 32'd1);
      check("t3_pk", 32'(frame_pk), 32'hFFF);
      @(posedge clk);
      #1;

      // Non-SOF bits in IDLE are dropped.
      for (int c = 0; c < 4; c++) begin
         sin_valid = 1'b1;
         sin_sof   = 1'b0;
         sin_data  = 1'b1;
         @(negedge clk);
         check("t4_idle_no_valid", 32'(frame_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      sin_valid = 1'b0;
      expect_frame(12'h0F0);
      send_word(12'h0F0);
      @(posedge clk);
      #1;
      check("t4_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Asynchronous reset while bit 7 is on the wire.
      send_bit(1'b1, 1'b1);
      for (int b = 0; b < 5; b++) send_bit(1'b0, b[0]);
      sin_valid = 1'b1;
      sin_data  = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("t5_rst_sin_ready", 32'(sin_ready), 32'd0);
      check("t5_rst_frame_valid", 32'(frame_valid), 32'd0);
      check("t5_rst_frame_pk", 32'(frame_pk), 32'd0);
      check("t5_rst_frame_up", 32'(up_as_flat()), 32'd0);
      check("t5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      sin_valid = 1'b0;
      sb_q.delete();
      exp_cnt = '0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      expect_frame(12'h5A5);
      send_word(12'h5A5);
      check("t5_pk_after_rst", 32'(frame_pk), 32'h5A5);
      @(posedge clk);
      #1;
      check("t5_cnt_after_rst", 32'(frame_cnt), 32'd1);

`ifdef FRAME12_DESER_PARITY_CHECK_EN
      // 12'h003 has even parity 0: parity bit 1 must be rejected, parity bit 0 accepted.
      for (int b = 11; b >= 0; b--) send_bit(b == 11, b < 2);
      send_bit(1'b0, 1'b1);
      check("t6_parity_err_pulse", 32'(parity_err), 32'd1);
      check("t6_parity_no_valid", 32'(frame_valid), 32'd0);
      @(negedge clk);
      check("t6_parity_err_one_cycle", 32'(parity_err), 32'd0);
      @(posedge clk);
      #1;
      expect_frame(12'h003);
      send_word(12'h003);
      check("t6_parity_ok_valid", 32'(frame_valid), 32'd1);
      @(posedge clk);
      #1;
`endif

      // Back-to-back frames until the 8-bit counter wraps to 0.
      n_wrap = 256 - int'(exp_cnt);
      for (int f = 0; f < n_wrap; f++) begin
         expect_frame(12'(f * 37 + 1));
         send_word(12'(f * 37 + 1));
      end
      @(posedge clk);
      #1;
      check("t7_cnt_wrap", 32'(frame_cnt), 32'd0);

      for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(posedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/frame12_deser.md
Name: frame12_deser

Overview:
- Serial-to-parallel receiver for the 12-bit shape [0:0][2:4][0:1][3:4] and its unpacked twin [3:4][3:2][2:4].
- Consumes a framed 1-bit stream (valid/ready, start-of-frame marker) and presents each completed frame in two views: packed and unpacked.
- Output side uses a valid/ready hold handshake.
- Sits downstream of any block that flattens these arrays onto a serial wire; it is the receive end of that link.

Parameters:
- FRAME_W, 12, bits per frame; fixed by the frame_t shape, not overridable in practice.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin_valid  input  1  serial bit present this cycle.
- sin_ready  output  1  receiver accepts a bit this cycle.
- sin_sof  input  1  qualifies sin_data as the first bit of a frame.
- sin_data  input  1  serial data bit.
- frame_valid  output  1  completed frame held on the outputs.
- frame_ready  input  1  consumer accepts the frame.
- frame_pk  output  12  packed view, type frame_t ([0:0][2:4][0:1][3:4]).
- frame_up  output  1 x [3:4][3:2][2:4]  unpacked view, type logic, same bits.
- frame_cnt  output  CNT_W  count of accepted frames, wraps modulo 2^CNT_W.
- err_resync  output  1  one-cycle pulse when a frame is aborted by an early SOF.

Behaviour:
- Transfer rules
  - A bit transfers on a cycle where sin_valid && sin_ready.
  - A frame transfers on a cycle where frame_valid && frame_ready.
- Reset values: sin_ready=0, frame_valid=0, frame_pk=0, frame_up all 0, frame_cnt=0, err_resync=0; state=IDLE; bit counter=0.
- Bit ordering
  - The first accepted bit lands in frame_pk flat bit 11, which is frame_pk[0][2][0][3].
  - Each subsequent bit goes to the next lower flat index; the last bit lands in flat bit 0, which is frame_pk[0][4][1][4].
  - frame_up[i][j][k] mirrors flat bit 11-n. n enumerates (i,j,k) in declared order with the rightmost index fastest: [3][3][2] is n=0, [4][2][4] is n=11.
- State machine (one-hot or binary, designer's choice)
  - IDLE: sin_ready=1. A transferred bit with sin_sof=1 stores bit 11, sets count=1, goes to SHIFT. A transferred bit with sin_sof=0 is dropped and the state stays IDLE.
  - SHIFT: sin_ready=1.
    - A transferred bit with sin_sof=0 stores the next bit and increments the count.
    - A transferred bit with sin_sof=1 discards the partial frame, stores this bit as bit 11, sets count=1 and pulses err_resync the next cycle.
    - When count reaches 12, go to PARITY if PARITY_CHECK_EN is defined, otherwise to HOLD.
  - HOLD: sin_ready=0, frame_valid=1.
    - Outputs are stable while frame_ready=0.
    - On a frame transfer: frame_cnt increments and wraps from 255 to 0; state goes to IDLE with sin_ready=1 the next cycle.
- Latency: frame_valid rises the cycle after the 12th bit transfers (or after the parity bit when parity is enabled).
- Throughput: at most one frame per 13 cycles without parity, 14 with parity.
- frame_pk and frame_up change only on the cycle the 12th bit is committed. The shift happens in an internal register and is not visible on the outputs mid-frame.
- Reset mid-frame: partial data is discarded and all outputs return to their reset values immediately (asynchronous).
- If sin_sof and sin_valid both arrive while in HOLD, they are not accepted (sin_ready=0). The source must hold them.

Optional Feature:
- Macro: FRAME12_DESER_PARITY_CHECK_EN.
- Defined:
  - After 12 data bits, state PARITY (sin_ready=1) accepts one more bit: the even parity over the 12 bits.
  - On a match: go to HOLD.
  - On a mismatch: drop the frame, return to IDLE, and pulse output port parity_err (1 bit, reset 0) for one cycle.
  - An early SOF in PARITY behaves as in SHIFT.
- Undefined: the PARITY state and the parity_err port do not exist; the frame completes after 12 bits.

Decomposition:
- Package frame12_pkg:
  - typedef logic [0:0][2:4][0:1][3:4] frame_t;
  - localparam FRAME_W = $bits(frame_t);
  - state enum state_t {IDLE, SHIFT, PARITY, HOLD}.
- Sub-module frame12_unpack: purely combinational frame_t to [3:4][3:2][2:4] mapping. It is reused by the matching transmitter in the reverse direction.

Test Plan:
- Stream SOF+bits 1,0,1,1,0,0,1,0,1,0,0,1 with frame_ready=1 -> frame_valid 1 cycle after the last bit; frame_pk=12'hB29; frame_up[3][3][2]=1, frame_up[4][2][4]=1; frame_cnt=1.
- Complete a frame with frame_ready=0 for 5 cycles -> frame_valid and data stable, sin_ready=0 throughout; frame_ready=1 -> next cycle frame_valid=0, sin_ready=1.
- SOF, 5 bits, then SOF again followed by 11 bits of 12'hFFF -> err_resync pulses once; frame_pk=12'hFFF; frame_cnt=1.
- Bits with sin_sof=0 while in IDLE -> ignored; frame_valid stays 0.
- Assert rst during bit 7 of a frame -> all outputs 0 in the same cycle; the next SOF frame of 12'h5A5 is received correctly.
- With parity enabled: 12'h003 with parity bit 1 -> parity_err pulse, no frame_valid. Same data with parity bit 0 -> frame accepted. Separately, 256 back-to-back frames -> frame_cnt returns to 0.
